// File: rtl/bounded_counter_if.sv
// Control/status bundle for bounded_counter. The master drives the count controls.
// The slave (the counter) returns the count value and its flags.
interface bounded_counter_if #(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4
);
  logic                  enable;
  logic                  load;
  logic [WIDTH-1:0]      valuein;
  logic                  decrement;
  logic [STEP_WIDTH-1:0] step;
  logic [WIDTH-1:0]      lowerbound;
  logic [WIDTH-1:0]      upperbound;
  logic                  saturate;
  logic [WIDTH-1:0]      valueout;
  logic                  atlower;
  logic                  atupper;
  logic                  overflow;
  logic                  underflow;
  logic                  boundserror;

  modport master (
    output enable, load, valuein, decrement, step, lowerbound, upperbound, saturate,
    input  valueout, atlower, atupper, overflow, underflow, boundserror
  );

  modport slave (
    input  enable, load, valuein, decrement, step, lowerbound, upperbound, saturate,
    output valueout, atlower, atupper, overflow, underflow, boundserror
  );
endinterface

// File: rtl/bounded_counter.sv
// Up/down counter with inclusive runtime bounds, variable step and wrap/saturate mode.
// Overflow and underflow are registered one-cycle pulses.
module bounded_counter #(
  parameter int               WIDTH       = 8,
  parameter int               STEP_WIDTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset,
  bounded_counter_if.slave   bus
);
  logic [WIDTH-1:0]        value_q, value_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic [WIDTH:0]          sum;
  logic signed [WIDTH+1:0] diff;
  logic                    bounds_bad;
  logic                    count_en;

  assign bounds_bad = bus.lowerbound > bus.upperbound;
  assign count_en   = bus.enable && (bus.step != '0) && !bounds_bad;

  // Widened arithmetic so the bound compare sees the true result, not a wrapped one.
  assign sum  = {1'b0, value_q} + {{(WIDTH+1-STEP_WIDTH){1'b0}}, bus.step};
  assign diff = $signed({2'b00, value_q}) - $signed({{(WIDTH+2-STEP_WIDTH){1'b0}}, bus.step});

  always_comb begin
    value_d = value_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (count_en) begin
      if (!bus.decrement) begin
        if (sum <= {1'b0, bus.upperbound}) begin
          value_d = sum[WIDTH-1:0];
        end else begin
          value_d = bus.saturate ? bus.upperbound : bus.lowerbound;
          ovf_d   = 1'b1;
        end
      end else begin
        if (diff >= $signed({2'b00, bus.lowerbound})) begin
          value_d = diff[WIDTH-1:0];
        end else begin
          value_d = bus.saturate ? bus.lowerbound : bus.upperbound;
          unf_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= RESET_VALUE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.load) begin
      value_q <= bus.valuein;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.valueout    = value_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.atlower     = value_q == bus.lowerbound;
  assign bus.atupper     = value_q == bus.upperbound;
  assign bus.boundserror = bounds_bad;
endmodule

// File: tb/tb_bounded_counter.sv
// Bench for bounded_counter: directed vector table, random run against an integer
// model, and a 16-bit instance for the widened overflow compare.
module tb_bounded_counter;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  bounded_counter_if #(.WIDTH(8),  .STEP_WIDTH(4)) bus8 ();
  bounded_counter_if #(.WIDTH(16), .STEP_WIDTH(8)) bus16 ();

  bounded_counter #(.WIDTH(8), .STEP_WIDTH(4), .RESET_VALUE(8'h10)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8)
  );
  bounded_counter #(.WIDTH(16), .STEP_WIDTH(8), .RESET_VALUE(16'h0000)) dut16 (
    .clock(clock), .reset(reset), .bus(bus16)
  );

  typedef struct {
    int rst, ld, en, dec, sat, st, lo, hi, vin;
    int e_val, e_ovf, e_unf, e_atl, e_atu, e_berr;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive8(input int rst, ld, en, dec, sat, st, lo, hi, vin);
    reset           = rst[0];
    bus8.load       = ld[0];
    bus8.enable     = en[0];
    bus8.decrement  = dec[0];
    bus8.saturate   = sat[0];
    bus8.step       = st[3:0];
    bus8.lowerbound = lo[7:0];
    bus8.upperbound = hi[7:0];
    bus8.valuein    = vin[7:0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check8(input string tag, input int v, ovf, unf, atl, atu, berr);
    chk({tag, ".value"},       int'(bus8.valueout),    v);
    chk({tag, ".overflow"},    int'(bus8.overflow),    ovf);
    chk({tag, ".underflow"},   int'(bus8.underflow),   unf);
    chk({tag, ".atlower"},     int'(bus8.atlower),     atl);
    chk({tag, ".atupper"},     int'(bus8.atupper),     atu);
    chk({tag, ".boundserror"}, int'(bus8.boundserror), berr);
  endtask

  initial begin
    int mv, s, d, ovf, unf;
    int rst, ld, en, dec, sat, st, lo, hi, vin;

    // rst ld en dec sat step lo hi vin | val ovf unf atl atu berr
    tbl.push_back('{1,1,0,0,0,0,'h00,'hFF,'h55, 'h10,0,0,0,0,0}); // reset beats load
    tbl.push_back('{0,1,0,0,0,0,'h00,'hFF,'hFE, 'hFE,0,0,0,0,0});
    tbl.push_back('{0,0,1,0,0,1,'h00,'hFF,'h00, 'hFF,0,0,0,1,0});
    tbl.push_back('{0,0,1,0,0,1,'h00,'hFF,'h00, 'h00,1,0,1,0,0}); // wrap
    tbl.push_back('{0,0,1,0,0,1,'h00,'hFF,'h00, 'h01,0,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,0,'h10,'h20,'h14, 'h14,0,0,0,0,0});
    tbl.push_back('{0,0,1,1,1,3,'h10,'h20,'h00, 'h11,0,0,0,0,0});
    tbl.push_back('{0,0,1,1,1,3,'h10,'h20,'h00, 'h10,0,1,1,0,0}); // clamp low
    tbl.push_back('{0,0,1,1,1,3,'h10,'h20,'h00, 'h10,0,1,1,0,0}); // re-pulse
    tbl.push_back('{0,1,0,0,0,0,'h10,'h20,'h1E, 'h1E,0,0,0,0,0});
    tbl.push_back('{0,0,1,0,0,5,'h10,'h20,'h00, 'h10,1,0,1,0,0});
    tbl.push_back('{0,1,1,0,0,5,'h10,'h20,'h30, 'h30,0,0,0,0,0}); // load wins
    tbl.push_back('{0,0,1,0,0,5,'h10,'h20,'h00, 'h10,1,0,1,0,0});
    tbl.push_back('{0,0,1,0,0,2,'h40,'h20,'h00, 'h10,0,0,0,0,1}); // bad bounds
    tbl.push_back('{0,0,1,0,0,0,'h10,'h20,'h00, 'h10,0,0,1,0,0}); // zero step
    tbl.push_back('{0,0,1,0,0,1,'h10,'h10,'h00, 'h10,1,0,1,1,0}); // lo == hi
    tbl.push_back('{0,1,0,0,0,0,'h10,'h20,'h30, 'h30,0,0,0,0,0});
    tbl.push_back('{0,0,1,1,0,5,'h10,'h20,'h00, 'h2B,0,0,0,0,0}); // down from above
    tbl.push_back('{1,0,1,0,0,1,'h10,'h20,'h00, 'h10,0,0,1,0,0}); // reset beats count

    bus16.load = 1'b0; bus16.enable = 1'b0; bus16.decrement = 1'b0;
    bus16.saturate = 1'b0; bus16.step = '0; bus16.valuein = '0;
    bus16.lowerbound = 16'h0000; bus16.upperbound = 16'hFFFF;
    drive8(1, 0, 0, 0, 0, 0, 0, 'hFF, 0);
    tick();

    foreach (tbl[i]) begin
      drive8(tbl[i].rst, tbl[i].ld, tbl[i].en, tbl[i].dec, tbl[i].sat,
             tbl[i].st, tbl[i].lo, tbl[i].hi, tbl[i].vin);
      tick();
      check8($sformatf("vec%0d", i), tbl[i].e_val, tbl[i].e_ovf, tbl[i].e_unf,
             tbl[i].e_atl, tbl[i].e_atu, tbl[i].e_berr);
    end

    // Random run: the model works on plain integers straight from the counting rules.
    mv = 'h10;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 9) != 0);
      dec = $urandom_range(0, 1);
      sat = $urandom_range(0, 1);
      st  = $urandom_range(0, 15);
      vin = $urandom_range(0, 255);
      lo  = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) hi = $urandom_range(0, 255);
      else                           hi = lo + $urandom_range(0, 255 - lo);
      ovf = 0;
      unf = 0;
      if (rst != 0)     mv = 'h10;
      else if (ld != 0) mv = vin;
      else if (en != 0 && st != 0 && lo <= hi) begin
        if (dec == 0) begin
          s = mv + st;
          if (s > hi) begin ovf = 1; mv = (sat != 0) ? hi : lo; end
          else mv = s;
        end else begin
          d = mv - st;
          if (d < lo) begin unf = 1; mv = (sat != 0) ? lo : hi; end
          else mv = d;
        end
      end
      drive8(rst, ld, en, dec, sat, st, lo, hi, vin);
      tick();
      check8($sformatf("rnd%0d", n), mv, ovf, unf, int'(mv == lo), int'(mv == hi),
             int'(lo > hi));
    end

    // 16-bit instance: FFF0 + FF must not wrap before the compare.
    drive8(0, 0, 0, 0, 0, 0, 0, 'hFF, 0);
    bus16.load = 1'b1; bus16.valuein = 16'hFFF0;
    tick();
    chk("w16.load", int'(bus16.valueout), 'hFFF0);
    bus16.load = 1'b0; bus16.enable = 1'b1; bus16.step = 8'hFF; bus16.saturate = 1'b1;
    tick();
    chk("w16.value",    int'(bus16.valueout), 'hFFFF);
    chk("w16.overflow", int'(bus16.overflow), 1);
    chk("w16.atupper",  int'(bus16.atupper),  1);
    bus16.enable = 1'b0;
    tick();
    chk("w16.hold",     int'(bus16.valueout), 'hFFFF);
    chk("w16.ovf_drop", int'(bus16.overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
